mq_host_slot_bank: RTL and testbench

- Parametrised multi-slot outbound message queue: node CPU pushes fixed-size messages, VME host pops them.
- Successor to the single-slot, host-polled HMQ outgoing path.
- Adds configurable slot count, depth and message size, plus interrupt coalescing, so the host no longer polls.
- Sits between the CPU-side MQ register decoder and the host-side VME/Wishbone slave.

---
 rtl/mq_host_slot_pkg.sv | 21 ++
 rtl/mq_host_slot_ctrl.sv | 59 +++++
 rtl/mq_host_slot_bank.sv | 196 +++++++++++++++++++
 tb/tb_mq_host_slot_bank.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mq_host_slot_pkg.sv
// Shared types and width helpers for the multi-slot outbound message queue.
package mq_host_slot_pkg;

  localparam int c_STAT_W = 16;

  typedef enum logic {
    IDLE    = 1'b0,
    CLAIMED = 1'b1
  } t_claim_state;

  // Slot select width; a single-slot bank still carries a 1-bit select.
  function automatic int slot_w(input int num_slots);
    return (num_slots > 1) ? $clog2(num_slots) : 1;
  endfunction

  // Occupancy needs one extra bit so that a full slot (2^E) is representable.
  function automatic int cnt_w(input int entries_log2);
    return entries_log2 + 1;
  endfunction

endpackage

// File: rtl/mq_host_slot_ctrl.sv
// Per-slot pointer/occupancy bookkeeping; optional overflow counter when
// MQ_HOST_SLOT_STATS_EN is defined.
module mq_host_slot_ctrl
  import mq_host_slot_pkg::*;
#(
  parameter int g_ENTRIES_LOG2 = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      commit,
  input  logic                      pop,
  output logic [g_ENTRIES_LOG2-1:0] wr_ptr,
  output logic [g_ENTRIES_LOG2-1:0] rd_ptr,
  output logic [g_ENTRIES_LOG2:0]   count,
  output logic                      full,
  output logic                      empty
`ifdef MQ_HOST_SLOT_STATS_EN
  ,
  input  logic                      ovf_hit,
  output logic [c_STAT_W-1:0]       overflow
`endif
);

  localparam int CW = cnt_w(g_ENTRIES_LOG2);

  logic pop_ok;

  // Pops against an empty slot are dropped here so the host cannot underflow.
  assign pop_ok = pop && !empty;
  assign full   = (count == CW'(2 ** g_ENTRIES_LOG2));
  assign empty  = (count == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (commit) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({commit, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef MQ_HOST_SLOT_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= '0;
    end else if (ovf_hit && (overflow != '1)) begin
      overflow <= overflow + 1'b1;
    end
  end
`endif

endmodule

// File: rtl/mq_host_slot_bank.sv
// Multi-slot outbound message queue (CPU producer, VME host consumer) with
// interrupt coalescing. Define MQ_HOST_SLOT_STATS_EN for per-slot overflow stats.
module mq_host_slot_bank
  import mq_host_slot_pkg::*;
#(
  parameter int g_NUM_SLOTS    = 4,
  parameter int g_ENTRIES_LOG2 = 2,
  parameter int g_WORDS_LOG2   = 4,
  parameter int g_DATA_W       = 32,
  parameter int g_COAL_W       = 16
) (
  input  logic                                          clk_sys_i,
  input  logic                                          rst_i,
  input  logic [slot_w(g_NUM_SLOTS)-1:0]                in_slot_i,
  input  logic                                          in_claim_i,
  output logic                                          in_claim_ok_o,
  output logic                                          in_claim_err_o,
  input  logic                                          in_we_i,
  input  logic [g_WORDS_LOG2-1:0]                       in_addr_i,
  input  logic [g_DATA_W-1:0]                           in_data_i,
  input  logic                                          in_commit_i,
  input  logic                                          in_discard_i,
  input  logic [slot_w(g_NUM_SLOTS)-1:0]                host_slot_i,
  input  logic [g_WORDS_LOG2-1:0]                       host_addr_i,
  output logic [g_DATA_W-1:0]                           host_data_o,
  input  logic                                          host_pop_i,
  output logic [g_NUM_SLOTS-1:0]                        slot_empty_o,
  output logic [g_NUM_SLOTS-1:0]                        slot_full_o,
  output logic [g_NUM_SLOTS*cnt_w(g_ENTRIES_LOG2)-1:0]  slot_count_o,
  input  logic [g_NUM_SLOTS-1:0]                        irq_mask_i,
  input  logic [g_COAL_W-1:0]                           coal_thresh_i,
  input  logic [g_COAL_W-1:0]                           coal_timeout_i,
  input  logic                                          irq_ack_i,
  output logic                                          irq_o,
  output logic [g_NUM_SLOTS*c_STAT_W-1:0]               stat_overflow_o
);

  localparam int SW    = slot_w(g_NUM_SLOTS);
  localparam int E     = g_ENTRIES_LOG2;
  localparam int CW    = cnt_w(g_ENTRIES_LOG2);
  localparam int AW    = SW + E + g_WORDS_LOG2;
  localparam int DEPTH = g_NUM_SLOTS * (2 ** (E + g_WORDS_LOG2));

  // Producer handshake: claim -> (claim_ok | claim_err) one cycle later;
  // writes/commit/discard are only honoured while a claim is held.
  t_claim_state   state, state_nxt;
  logic [SW-1:0]  slot_q, slot_nxt;
  logic           ok_q, ok_nxt, err_q, err_nxt;
  logic           commit_fire;
  logic           slot_valid, in_full;

  logic [E-1:0]   wr_ptr [g_NUM_SLOTS];
  logic [E-1:0]   rd_ptr [g_NUM_SLOTS];
  logic [CW-1:0]  count  [g_NUM_SLOTS];
  logic [g_NUM_SLOTS-1:0] full, empty, commit_vec, pop_vec;

  logic [g_DATA_W-1:0] ram [0:DEPTH-1];
  logic                ram_we;
  logic [AW-1:0]       wr_addr, rd_addr;

  logic [g_COAL_W-1:0] pend_cnt, pend_nxt, timer, timer_nxt, thresh_eff;
  logic                irq_q, irq_nxt, counted, fire;

  assign slot_valid = ({1'b0, in_slot_i} < (SW + 1)'(g_NUM_SLOTS));
  assign in_full    = slot_valid ? full[in_slot_i] : 1'b1;

  always_ff @(posedge clk_sys_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= IDLE;
      slot_q <= '0;
      ok_q   <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      slot_q <= slot_nxt;
      ok_q   <= ok_nxt;
      err_q  <= err_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    slot_nxt    = slot_q;
    ok_nxt      = 1'b0;
    err_nxt     = 1'b0;
    commit_fire = 1'b0;
    case (state)
      IDLE: begin
        if (in_claim_i) begin
          if (in_full) begin
            err_nxt = 1'b1;
          end else begin
            state_nxt = CLAIMED;
            slot_nxt  = in_slot_i;
            ok_nxt    = 1'b1;
          end
        end
      end
      CLAIMED: begin
        if (in_claim_i) err_nxt = 1'b1;
        if (in_commit_i) begin
          commit_fire = 1'b1;
          state_nxt   = IDLE;
        end else if (in_discard_i) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign in_claim_ok_o  = ok_q;
  assign in_claim_err_o = err_q;

  for (genvar g = 0; g < g_NUM_SLOTS; g++) begin : g_slot
    assign commit_vec[g] = commit_fire && (slot_q == SW'(g));
    assign pop_vec[g]    = host_pop_i && (host_slot_i == SW'(g));

    mq_host_slot_ctrl #(
      .g_ENTRIES_LOG2(E)
    ) u_ctrl (
      .clk      (clk_sys_i),
      .rst      (rst_i),
      .commit   (commit_vec[g]),
      .pop      (pop_vec[g]),
      .wr_ptr   (wr_ptr[g]),
      .rd_ptr   (rd_ptr[g]),
      .count    (count[g]),
      .full     (full[g]),
      .empty    (empty[g])
`ifdef MQ_HOST_SLOT_STATS_EN
      ,
      .ovf_hit  ((state == IDLE) && in_claim_i && slot_valid && full[g] &&
                 (in_slot_i == SW'(g))),
      .overflow (stat_overflow_o[g*c_STAT_W +: c_STAT_W])
`endif
    );

    assign slot_count_o[g*CW +: CW] = count[g];
  end

`ifndef MQ_HOST_SLOT_STATS_EN
  assign stat_overflow_o = '0;
`endif

  assign slot_full_o  = full;
  assign slot_empty_o = empty;

  assign ram_we  = (state == CLAIMED) && in_we_i;
  assign wr_addr = {slot_q, wr_ptr[slot_q], in_addr_i};
  assign rd_addr = {host_slot_i, rd_ptr[host_slot_i], host_addr_i};

  always_ff @(posedge clk_sys_i) begin
    if (ram_we) ram[wr_addr] <= in_data_i;
  end

  always_ff @(posedge clk_sys_i or posedge rst_i) begin
    if (rst_i) host_data_o <= '0;
    else       host_data_o <= ram[rd_addr];
  end

  // Coalescing works on next-state values so that the commit cycle counts as
  // the first timer tick: threshold 1 and timeout 1 both fire one cycle later.
  assign counted    = commit_fire && irq_mask_i[slot_q];
  assign thresh_eff = (coal_thresh_i == '0) ? g_COAL_W'(1) : coal_thresh_i;

  always_comb begin
    pend_nxt  = pend_cnt;
    timer_nxt = timer;
    if (irq_ack_i)                         pend_nxt = counted ? g_COAL_W'(1) : '0;
    else if (counted && (pend_cnt != '1))  pend_nxt = pend_cnt + 1'b1;

    if (pend_nxt == '0)                    timer_nxt = '0;
    else if (irq_ack_i || pend_cnt == '0)  timer_nxt = g_COAL_W'(1);
    else if (timer != '1)                  timer_nxt = timer + 1'b1;

    fire = (pend_nxt >= thresh_eff) ||
           ((coal_timeout_i != '0) && (timer_nxt == coal_timeout_i));
    irq_nxt = irq_ack_i ? 1'b0 : (irq_q || fire);
  end

  always_ff @(posedge clk_sys_i or posedge rst_i) begin
    if (rst_i) begin
      pend_cnt <= '0;
      timer    <= '0;
      irq_q    <= 1'b0;
    end else begin
      pend_cnt <= pend_nxt;
      timer    <= timer_nxt;
      irq_q    <= irq_nxt;
    end
  end

  assign irq_o = irq_q;

endmodule

// File: tb/tb_mq_host_slot_bank.sv
// Self-checking bench for mq_host_slot_bank: per-slot scoreboard queues hold
// the base value of each committed message (word i = base + i).
module tb_mq_host_slot_bank;

  localparam int N  = 4;
  localparam int CW = 3;
  localparam int DW = 32;

  logic          clk_sys_i = 1'b0;
  logic          rst_i     = 1'b1;
  logic [1:0]    in_slot_i = '0;
  logic          in_claim_i = 1'b0;
  logic          in_claim_ok_o, in_claim_err_o;
  logic          in_we_i = 1'b0;
  logic [3:0]    in_addr_i = '0;
  logic [DW-1:0] in_data_i = '0;
  logic          in_commit_i = 1'b0;
  logic          in_discard_i = 1'b0;
  logic [1:0]    host_slot_i = '0;
  logic [3:0]    host_addr_i = '0;
  logic [DW-1:0] host_data_o;
  logic          host_pop_i = 1'b0;
  logic [N-1:0]  slot_empty_o, slot_full_o;
  logic [N*CW-1:0] slot_count_o;
  logic [N-1:0]  irq_mask_i = '0;
  logic [15:0]   coal_thresh_i = '0;
  logic [15:0]   coal_timeout_i = '0;
  logic          irq_ack_i = 1'b0;
  logic          irq_o;
  logic [N*16-1:0] stat_overflow_o;

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [DW-1:0] exp_q [0:N-1][$];

  mq_host_slot_bank dut (
    .clk_sys_i       (clk_sys_i),
    .rst_i           (rst_i),
    .in_slot_i       (in_slot_i),
    .in_claim_i      (in_claim_i),
    .in_claim_ok_o   (in_claim_ok_o),
    .in_claim_err_o  (in_claim_err_o),
    .in_we_i         (in_we_i),
    .in_addr_i       (in_addr_i),
    .in_data_i       (in_data_i),
    .in_commit_i     (in_commit_i),
    .in_discard_i    (in_discard_i),
    .host_slot_i     (host_slot_i),
    .host_addr_i     (host_addr_i),
    .host_data_o     (host_data_o),
    .host_pop_i      (host_pop_i),
    .slot_empty_o    (slot_empty_o),
    .slot_full_o     (slot_full_o),
    .slot_count_o    (slot_count_o),
    .irq_mask_i      (irq_mask_i),
    .coal_thresh_i   (coal_thresh_i),
    .coal_timeout_i  (coal_timeout_i),
    .irq_ack_i       (irq_ack_i),
    .irq_o           (irq_o),
    .stat_overflow_o (stat_overflow_o)
  );

  // Clock/reset: inputs change and outputs are sampled on the falling edge.
  always #5 clk_sys_i = ~clk_sys_i;

  task automatic tick();
    @(negedge clk_sys_i);
  endtask

  // ---------------- driver tasks ----------------
  task automatic claim(input int s, output logic ok, output logic err);
    in_slot_i  = 2'(s);
    in_claim_i = 1'b1;
    tick();
    in_claim_i = 1'b0;
    ok  = in_claim_ok_o;
    err = in_claim_err_o;
  endtask

  task automatic fill(input logic [DW-1:0] base, input int nw);
    for (int i = 0; i < nw; i++) begin
      in_addr_i = 4'(i);
      in_data_i = base + DW'(i);
      in_we_i   = 1'b1;
      tick();
    end
    in_we_i = 1'b0;
  endtask

  task automatic send(input int s, input logic [DW-1:0] base, input bit ack);
    logic ok, err;
    claim(s, ok, err);
    total_cnt++;
    if ({ok, err} !== 2'b10) $display("FAIL send_claim slot %0d: ok/err=%b required 10", s, {ok, err});
    else pass_cnt++;
    fill(base, 16);
    in_commit_i = 1'b1;
    irq_ack_i   = ack;
    tick();
    in_commit_i = 1'b0;
    irq_ack_i   = 1'b0;
    exp_q[s].push_back(base);
  endtask

  // Scoreboard consumer: read the head entry word by word, then pop it.
  task automatic read_pop(input int s);
    logic [DW-1:0] base;
    total_cnt++;
    if (exp_q[s].size() == 0) begin
      $display("FAIL read_pop slot %0d: scoreboard empty", s);
      return;
    end
    pass_cnt++;
    base = exp_q[s].pop_front();
    for (int i = 0; i < 16; i++) begin
      host_slot_i = 2'(s);
      host_addr_i = 4'(i);
      tick();
      total_cnt++;
      if (host_data_o !== base + DW'(i))
        $display("FAIL host_data slot %0d word %0d: got %h required %h", s, i, host_data_o, base + DW'(i));
      else pass_cnt++;
    end
    host_pop_i = 1'b1;
    tick();
    host_pop_i = 1'b0;
  endtask

  task automatic drain_all();
    for (int s = 0; s < N; s++)
      while (exp_q[s].size() > 0) read_pop(s);
    total_cnt++;
    if (slot_empty_o !== 4'hF || slot_count_o !== '0)
      $display("FAIL drain_empty: empty=%b count=%h required 1111/000", slot_empty_o, slot_count_o);
    else pass_cnt++;
  endtask

  function automatic logic [DW-1:0] rnd_base();
    return DW'($urandom_range(0, 32'h00FF_FFFF)) << 8;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) tick();
    rst_i = 1'b0;
    total_cnt++;
    if (slot_empty_o !== 4'hF) $display("FAIL reset_empty: got %b required 1111", slot_empty_o);
    else pass_cnt++;
    total_cnt++;
    if (slot_full_o !== 4'h0 || slot_count_o !== '0)
      $display("FAIL reset_full_count: full=%b count=%h required 0", slot_full_o, slot_count_o);
    else pass_cnt++;
    total_cnt++;
    if ({irq_o, in_claim_ok_o, in_claim_err_o} !== 3'b000 || host_data_o !== '0 || stat_overflow_o !== '0)
      $display("FAIL reset_outputs: irq/ok/err=%b data=%h stat=%h required 0", {irq_o, in_claim_ok_o, in_claim_err_o}, host_data_o, stat_overflow_o);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    send(2, 32'h100, 1'b0);
    total_cnt++;
    if (slot_count_o[2*CW +: CW] !== 3'd1 || slot_empty_o[2] !== 1'b0)
      $display("FAIL basic_count: count2=%0d empty2=%b required 1/0", slot_count_o[2*CW +: CW], slot_empty_o[2]);
    else pass_cnt++;
    read_pop(2);
    total_cnt++;
    if (slot_empty_o[2] !== 1'b1) $display("FAIL basic_pop_empty: got %b required 1", slot_empty_o[2]);
    else pass_cnt++;
  endtask

  task automatic test_full();
    logic ok, err;
    for (int k = 0; k < 4; k++) send(0, rnd_base(), 1'b0);
    total_cnt++;
    if (slot_full_o[0] !== 1'b1 || slot_count_o[0 +: CW] !== 3'd4)
      $display("FAIL full_flag: full0=%b count0=%0d required 1/4", slot_full_o[0], slot_count_o[0 +: CW]);
    else pass_cnt++;
    claim(0, ok, err);
    total_cnt++;
    if ({ok, err} !== 2'b01) $display("FAIL full_claim_err: ok/err=%b required 01", {ok, err});
    else pass_cnt++;
    total_cnt++;
`ifdef MQ_HOST_SLOT_STATS_EN
    if (stat_overflow_o[15:0] !== 16'd1) $display("FAIL stat_overflow0: got %0d required 1", stat_overflow_o[15:0]);
`else
    if (stat_overflow_o !== '0) $display("FAIL stat_overflow0: got %h required 0", stat_overflow_o);
`endif
    else pass_cnt++;
    // Second claim while one is held is refused without touching any counter.
    claim(3, ok, err);
    fill(32'hDEAD_0000, 3);
    claim(1, ok, err);
    total_cnt++;
    if ({ok, err} !== 2'b01 || stat_overflow_o[31:16] !== 16'd0)
      $display("FAIL held_claim_err: ok/err=%b stat1=%0d required 01/0", {ok, err}, stat_overflow_o[31:16]);
    else pass_cnt++;
    in_discard_i = 1'b1;
    tick();
    in_discard_i = 1'b0;
    in_commit_i = 1'b1;
    in_we_i = 1'b1;
    tick();
    in_commit_i = 1'b0;
    in_we_i = 1'b0;
    total_cnt++;
    if (slot_count_o[3*CW +: CW] !== 3'd0) $display("FAIL discard_idle_commit: count3=%0d required 0", slot_count_o[3*CW +: CW]);
    else pass_cnt++;
    // Commit and discard together: commit wins.
    claim(3, ok, err);
    fill(32'h3300, 16);
    in_commit_i = 1'b1;
    in_discard_i = 1'b1;
    tick();
    in_commit_i = 1'b0;
    in_discard_i = 1'b0;
    exp_q[3].push_back(32'h3300);
    total_cnt++;
    if (slot_count_o[3*CW +: CW] !== 3'd1) $display("FAIL commit_wins: count3=%0d required 1", slot_count_o[3*CW +: CW]);
    else pass_cnt++;
    read_pop(0);
    total_cnt++;
    if (slot_full_o[0] !== 1'b0) $display("FAIL full_after_pop: got %b required 0", slot_full_o[0]);
    else pass_cnt++;
    send(0, rnd_base(), 1'b0);
    drain_all();
  endtask

  task automatic test_back_to_back();
    logic ok, err;
    logic [DW-1:0] b;
    send(1, rnd_base(), 1'b0);
    send(1, rnd_base(), 1'b0);
    b = rnd_base();
    claim(1, ok, err);
    fill(b, 16);
    void'(exp_q[1].pop_front());
    host_slot_i = 2'd1;
    in_commit_i = 1'b1;
    host_pop_i  = 1'b1;
    tick();
    in_commit_i = 1'b0;
    host_pop_i  = 1'b0;
    exp_q[1].push_back(b);
    total_cnt++;
    if (slot_count_o[CW +: CW] !== 3'd2) $display("FAIL same_cycle_count: count1=%0d required 2", slot_count_o[CW +: CW]);
    else pass_cnt++;
    drain_all();
  endtask

  task automatic test_irq_thresh();
    irq_mask_i = 4'hF;
    coal_thresh_i = 16'd3;
    coal_timeout_i = 16'd0;
    send(0, rnd_base(), 1'b0);
    send(1, rnd_base(), 1'b0);
    total_cnt++;
    if (irq_o !== 1'b0) $display("FAIL irq_before_thresh: got %b required 0", irq_o);
    else pass_cnt++;
    send(2, rnd_base(), 1'b0);
    total_cnt++;
    if (irq_o !== 1'b1) $display("FAIL irq_at_thresh: got %b required 1", irq_o);
    else pass_cnt++;
    send(3, rnd_base(), 1'b1);
    total_cnt++;
    if (irq_o !== 1'b0) $display("FAIL irq_ack_clear: got %b required 0", irq_o);
    else pass_cnt++;
    send(0, rnd_base(), 1'b0);
    total_cnt++;
    if (irq_o !== 1'b0) $display("FAIL irq_pend2: got %b required 0", irq_o);
    else pass_cnt++;
    send(1, rnd_base(), 1'b0);
    total_cnt++;
    if (irq_o !== 1'b1) $display("FAIL irq_ack_cycle_commit_kept: got %b required 1", irq_o);
    else pass_cnt++;
    irq_ack_i = 1'b1;
    tick();
    irq_ack_i = 1'b0;
    drain_all();
  endtask

  task automatic test_irq_timeout();
    int seen;
    coal_thresh_i = 16'd10;
    coal_timeout_i = 16'd50;
    send(2, rnd_base(), 1'b0);
    repeat (48) tick();
    total_cnt++;
    if (irq_o !== 1'b0) $display("FAIL irq_timeout_early: got %b required 0 at cycle 49", irq_o);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (irq_o !== 1'b1) $display("FAIL irq_timeout_50: got %b required 1 at cycle 50", irq_o);
    else pass_cnt++;
    irq_ack_i = 1'b1;
    tick();
    irq_ack_i = 1'b0;
    irq_mask_i = 4'b1011;
    coal_thresh_i = 16'd1;
    coal_timeout_i = 16'd5;
    send(2, rnd_base(), 1'b0);
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      if (irq_o !== 1'b0) seen++;
      tick();
    end
    total_cnt++;
    if (seen != 0) $display("FAIL irq_masked_slot: irq high for %0d cycles required 0", seen);
    else pass_cnt++;
    send(0, rnd_base(), 1'b0);
    total_cnt++;
    if (irq_o !== 1'b1) $display("FAIL irq_unmasked_slot: got %b required 1", irq_o);
    else pass_cnt++;
    irq_ack_i = 1'b1;
    tick();
    irq_ack_i = 1'b0;
    drain_all();
  endtask

  task automatic test_reset_mid();
    logic ok, err;
    irq_mask_i = 4'hF;
    coal_thresh_i = 16'd1;
    coal_timeout_i = 16'd0;
    send(1, rnd_base(), 1'b0);
    total_cnt++;
    if (irq_o !== 1'b1) $display("FAIL pre_reset_irq: got %b required 1", irq_o);
    else pass_cnt++;
    claim(3, ok, err);
    fill(rnd_base(), 5);
    rst_i = 1'b1;
    repeat (2) tick();
    rst_i = 1'b0;
    for (int s = 0; s < N; s++) exp_q[s].delete();
    total_cnt++;
    if (slot_count_o !== '0 || slot_empty_o !== 4'hF || irq_o !== 1'b0 || stat_overflow_o !== '0)
      $display("FAIL mid_reset: count=%h empty=%b irq=%b stat=%h required 0/1111/0/0", slot_count_o, slot_empty_o, irq_o, stat_overflow_o);
    else pass_cnt++;
    claim(3, ok, err);
    total_cnt++;
    if ({ok, err} !== 2'b10) $display("FAIL post_reset_claim: ok/err=%b required 10", {ok, err});
    else pass_cnt++;
    in_discard_i = 1'b1;
    tick();
    in_discard_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_back_to_back();
    test_irq_thresh();
    test_irq_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
